// File: rtl/tic_sat.sv
// rtl/tic_sat.sv - 4x4 int8 weight-stationary matrix unit on a custom-instruction port
module tic_sat #(
    parameter int N     = 4,
    parameter int ACC_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [8*N-1:0]     tic_in,
    input  logic [1:0]         command,
    input  logic [1:0]         col,
    output logic [ACC_W-1:0]   tic_out
);

    localparam logic [1:0] CMD_LOAD_W   = 2'b00;
    localparam logic [1:0] CMD_MAC      = 2'b01;
    localparam logic [1:0] CMD_MAC_LAST = 2'b10;
    localparam logic [1:0] CMD_CLEAR    = 2'b11;

    logic signed [7:0]       w_q    [N][N];
    logic signed [7:0]       w_d    [N][N];
    logic signed [ACC_W-1:0] acc_q  [N];
    logic signed [ACC_W-1:0] acc_d  [N];
    logic signed [ACC_W-1:0] obuf_q [N];
    logic signed [ACC_W-1:0] obuf_d [N];
    logic [ACC_W-1:0]        tic_out_q;
    logic [ACC_W-1:0]        tic_out_d;

    logic signed [7:0]       lane [N];
    logic signed [15:0]      prod [N][N];
    logic signed [ACC_W-1:0] dot  [N];

    // Column dot products: every weight column sees the same activation vector.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            lane[r] = tic_in[8*r +: 8];
        end
        for (int c = 0; c < N; c++) begin
            dot[c] = '0;
            for (int r = 0; r < N; r++) begin
                prod[r][c] = lane[r] * w_q[r][c];
                dot[c]     = dot[c] + {{(ACC_W-16){prod[r][c][15]}}, prod[r][c]};
            end
        end
    end

    always_comb begin
        w_d       = w_q;
        acc_d     = acc_q;
        obuf_d    = obuf_q;
        tic_out_d = obuf_q[col];
        case (command)
            CMD_LOAD_W: begin
                for (int r = 0; r < N; r++) begin
                    w_d[r][col] = lane[r];
                end
            end
            CMD_MAC: begin
                for (int c = 0; c < N; c++) begin
                    acc_d[c] = acc_q[c] + dot[c];
                end
            end
            CMD_MAC_LAST: begin
                for (int c = 0; c < N; c++) begin
                    obuf_d[c] = acc_q[c] + dot[c];
                    acc_d[c]  = '0;
                end
            end
            CMD_CLEAR: begin
                for (int c = 0; c < N; c++) begin
                    acc_d[c] = '0;
                end
            end
            default: ;
        endcase
    end

    // resetn is active-high here despite its name.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int c = 0; c < N; c++) begin
                for (int r = 0; r < N; r++) begin
                    w_q[r][c] <= '0;
                end
                acc_q[c]  <= '0;
                obuf_q[c] <= '0;
            end
            tic_out_q <= '0;
        end else begin
            w_q       <= w_d;
            acc_q     <= acc_d;
            obuf_q    <= obuf_d;
            tic_out_q <= tic_out_d;
        end
    end

    assign tic_out = tic_out_q;

endmodule

// File: tb/tb_tic_sat.sv
// tb/tb_tic_sat.sv - randomized and directed checks of tic_sat against an arithmetic model
module tb_tic_sat;

    localparam logic [1:0] LOAD_W   = 2'b00;
    localparam logic [1:0] MAC      = 2'b01;
    localparam logic [1:0] MAC_LAST = 2'b10;
    localparam logic [1:0] CLEAR    = 2'b11;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] tic_in;
    logic [1:0]  command;
    logic [1:0]  col;
    logic [31:0] tic_out;

    int total = 0;
    int bad   = 0;

    int m_w    [4][4];
    int m_acc  [4];
    int m_obuf [4];

    tic_sat dut (
        .clk     (clk),
        .resetn  (resetn),
        .tic_in  (tic_in),
        .command (command),
        .col     (col),
        .tic_out (tic_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int lane_of(input logic [31:0] d, input int r);
        logic [7:0] b;
        b = d[8*r +: 8];
        return int'(byte'(b));
    endfunction

    function automatic int dot_of(input logic [31:0] d, input int c);
        int s;
        s = 0;
        for (int r = 0; r < 4; r++) s += lane_of(d, r) * m_w[r][c];
        return s;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) m_w[r][c] = 0;
            m_acc[c]  = 0;
            m_obuf[c] = 0;
        end
    endtask

    // One clock: drive, let the edge happen, update the model, compare tic_out.
    task automatic step(input logic [1:0] cmd, input logic [31:0] d, input logic [1:0] c);
        int exp_out;
        int dots [4];
        command = cmd;
        tic_in  = d;
        col     = c;
        @(posedge clk);
        #1;
        exp_out = m_obuf[c];
        for (int k = 0; k < 4; k++) dots[k] = dot_of(d, k);
        case (cmd)
            LOAD_W:   for (int r = 0; r < 4; r++) m_w[r][c] = lane_of(d, r);
            MAC:      for (int k = 0; k < 4; k++) m_acc[k] = m_acc[k] + dots[k];
            MAC_LAST: for (int k = 0; k < 4; k++) begin
                          m_obuf[k] = m_acc[k] + dots[k];
                          m_acc[k]  = 0;
                      end
            default:  for (int k = 0; k < 4; k++) m_acc[k] = 0;
        endcase
        check("out", tic_out, exp_out);
    endtask

    task automatic read_col(input logic [1:0] c, input logic [31:0] exp, input string tag);
        step(MAC, 32'h0, c);
        check(tag, tic_out, exp);
    endtask

    task automatic pulse_reset();
        #2 resetn = 1'b1;
        #1 check("rst_async", tic_out, 32'h0);
        model_reset();
        @(posedge clk);
        #1 check("rst_hold", tic_out, 32'h0);
        resetn = 1'b0;
    endtask

    initial begin
        resetn  = 1'b1;
        tic_in  = '0;
        command = LOAD_W;
        col     = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check("reset_state", tic_out, 32'h0);
        resetn = 1'b0;

        // Uniform weights, four-cycle accumulation
        for (int c = 0; c < 4; c++) step(LOAD_W, 32'h11011202, 2'(c));
        step(MAC, 32'h11011202, 0);
        step(MAC, 32'h11011202, 0);
        step(MAC, 32'h11011202, 0);
        step(MAC_LAST, 32'h11011202, 0);
        for (int c = 0; c < 4; c++) read_col(2'(c), 32'd2472, "uniform");

        // Accumulator restarted by MAC_LAST
        step(MAC, 32'h00010003, 0);
        step(MAC, 32'h00010003, 0);
        step(MAC, 32'h00010003, 0);
        step(MAC_LAST, 32'h00010003, 0);
        for (int c = 0; c < 4; c++) read_col(2'(c), 32'd28, "restart");

        // Signed extremes
        step(LOAD_W, 32'h80808080, 0);
        for (int c = 1; c < 4; c++) step(LOAD_W, 32'h01010101, 2'(c));
        step(MAC_LAST, 32'h80808080, 0);
        read_col(0, 32'd65536, "signed_c0");
        for (int c = 1; c < 4; c++) read_col(2'(c), 32'hFFFFFE00, "signed_cn");

        // Per-column distinction
        for (int c = 0; c < 4; c++) step(LOAD_W, 32'(c + 1), 2'(c));
        step(MAC_LAST, 32'h00000005, 0);
        for (int c = 0; c < 4; c++) read_col(2'(c), 32'(5 * (c + 1)), "percol");

        // CLEAR discards acc but leaves obuf until the next MAC_LAST
        step(MAC, 32'h00000007, 0);
        step(CLEAR, 32'h00000007, 0);
        read_col(3, 32'd20, "clear_keep");
        step(MAC_LAST, 32'h0, 0);
        for (int c = 0; c < 4; c++) read_col(2'(c), 32'h0, "clear_zero");

        // Wrap: 0x8000 * 65536 = 2^31
        for (int c = 0; c < 4; c++) step(LOAD_W, 32'h80808080, 2'(c));
        for (int i = 0; i < 32'h8000; i++) step(MAC, 32'h80808080, 2'(i));
        step(MAC_LAST, 32'h0, 0);
        for (int c = 0; c < 4; c++) read_col(2'(c), 32'h80000000, "wrap");

        // Reset mid-operation clears weights too
        for (int c = 0; c < 4; c++) step(LOAD_W, 32'h05050505, 2'(c));
        step(MAC_LAST, 32'h01010101, 1);
        step(MAC, 32'h01010101, 1);
        pulse_reset();
        step(MAC_LAST, 32'h7F7F7F7F, 0);
        for (int c = 0; c < 4; c++) read_col(2'(c), 32'h0, "post_reset");

        // Randomized traffic, with occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) pulse_reset();
            step(2'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
